// File: rtl/except_ctrl_pkg.sv
// except_ctrl shared definitions:
// exception codes, CP0 addresses, FSM states
package except_ctrl_pkg;

  localparam logic [31:0] EXC_INT     = 32'h1;
  localparam logic [31:0] EXC_SYSCALL = 32'h8;
  localparam logic [31:0] EXC_RI      = 32'ha;
  localparam logic [31:0] EXC_TRAP    = 32'hd;
  localparam logic [31:0] EXC_OV      = 32'hc;
  localparam logic [31:0] EXC_ERET    = 32'he;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_CONFIG  = 5'd16;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;

  localparam int CNT_W = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/except_ctrl_int_sync.sv
// except_ctrl interrupt synchroniser:
// STAGES-deep 6-bit flop chain, no edge detection
module except_ctrl_int_sync #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] int_i,
  output logic [5:0] sync_o
);

  logic [STAGES*6-1:0] chain_d;
  logic [STAGES*6-1:0] chain_q;

  // shift raw lines into the chain
  always_comb begin
    chain_d = {chain_q[(STAGES-1)*6-1:0], int_i};
  end

  // chain registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain_q <= '0;
    else      chain_q <= chain_d;
  end

  assign sync_o = chain_q[STAGES*6-1 -: 6];

endmodule

// File: rtl/except_ctrl.sv
// except_ctrl: MEM-stage exception initiator,
// issues excepttype to CP0 and sequences flush/redirect
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        mem_valid_i,
  input  logic [4:0]  mem_exc_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] cp0_pc_o,
  output logic        cp0_in_delayslot_o,
  output logic [5:0]  cp0_int_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  state_t             state_d, state_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [31:0]        exc_d, exc_q;
  logic [31:0]        pc_d, pc_q;
  logic               ds_d, ds_q;
  logic               flush_d, flush_q;
  logic [31:0]        npc_d, npc_q;

  logic [31:0] status_fwd;
  logic [31:0] cause_fwd;
  logic [31:0] epc_fwd;
  logic        int_pend;
  logic [31:0] code;
  logic        unused_ok;

  except_ctrl_int_sync #(
    .STAGES(SYNC_STAGES)
  ) u_int_sync (
    .clk   (clk),
    .rst   (rst),
    .int_i (int_i),
    .sync_o(cp0_int_o)
  );

  // WB-stage CP0 write forwarding
  always_comb begin
    status_fwd = cp0_status_i;
    cause_fwd  = cp0_cause_i;
    epc_fwd    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      unique case (wb_cp0_waddr_i)
        CP0_STATUS: status_fwd = wb_cp0_data_i;
        CP0_EPC:    epc_fwd    = wb_cp0_data_i;
        CP0_CAUSE: begin
          cause_fwd[9:8]   = wb_cp0_data_i[9:8];
          cause_fwd[23:22] = wb_cp0_data_i[23:22];
        end
        default: ;
      endcase
    end
  end

  // pending interrupt and prioritised exception code
  always_comb begin
    int_pend = (|(cause_fwd[15:8] & status_fwd[15:8]))
             & status_fwd[ST_IE] & ~status_fwd[ST_EXL];
    code = '0;
    if (mem_valid_i) begin
      priority case (1'b1)
        int_pend:     code = EXC_INT;
        mem_exc_i[0]: code = EXC_SYSCALL;
        mem_exc_i[1]: code = EXC_RI;
        mem_exc_i[2]: code = EXC_TRAP;
        mem_exc_i[3]: code = EXC_OV;
        mem_exc_i[4]: code = EXC_ERET;
        default:      code = '0;
      endcase
    end
  end

  assign unused_ok = ^{status_fwd[31:16], status_fwd[7:2],
                       cause_fwd[31:16], cause_fwd[7:0]};

  // next state: issue in IDLE, count down in FLUSH
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exc_d   = '0;
    pc_d    = pc_q;
    ds_d    = ds_q;
    flush_d = flush_q;
    npc_d   = npc_q;
    unique case (state_q)
      S_IDLE: begin
        pc_d    = '0;
        ds_d    = 1'b0;
        flush_d = 1'b0;
        npc_d   = '0;
        if (code != '0) begin
          exc_d   = code;
          pc_d    = mem_pc_i;
          ds_d    = mem_in_delayslot_i;
          flush_d = 1'b1;
          npc_d   = (code == EXC_ERET) ? epc_fwd : EXC_VECTOR;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          pc_d    = '0;
          ds_d    = 1'b0;
          flush_d = 1'b0;
          npc_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      exc_q   <= '0;
      pc_q    <= '0;
      ds_q    <= 1'b0;
      flush_q <= 1'b0;
      npc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
      pc_q    <= pc_d;
      ds_q    <= ds_d;
      flush_q <= flush_d;
      npc_q   <= npc_d;
    end
  end

  assign excepttype_o       = exc_q;
  assign cp0_pc_o           = pc_q;
  assign cp0_in_delayslot_o = ds_q;
  assign flush_o            = flush_q;
  assign new_pc_o           = npc_q;
  assign busy_o             = (state_q != S_IDLE);

endmodule

// File: tb/tb_except_ctrl.sv
// tb_except_ctrl: directed + random stimulus,
// two DUT configs checked against a rule-level model
module tb_except_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic        mem_valid;
  logic [4:0]  mem_exc;
  logic [31:0] mem_pc;
  logic        mem_ds;
  logic [31:0] status, cause, epc;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_data;

  logic [31:0] exc_o[2];
  logic [31:0] pc_o[2];
  logic        ds_o[2];
  logic [5:0]  int_o[2];
  logic        flush_o[2];
  logic [31:0] npc_o[2];
  logic        busy_o[2];

  int n_chk = 0;
  int n_err = 0;

  int          m_left[2];
  logic [31:0] e_exc[2], e_pc[2], e_npc[2];
  logic        e_ds[2], e_flush[2];
  int          fc[2] = '{2, 1};
  int          ss[2] = '{2, 3};
  logic [5:0]  hist[$];

  always #5 clk = ~clk;

  except_ctrl u_dut0 (
    .clk(clk), .rst(rst), .int_i(int_i),
    .mem_valid_i(mem_valid), .mem_exc_i(mem_exc),
    .mem_pc_i(mem_pc), .mem_in_delayslot_i(mem_ds),
    .cp0_status_i(status), .cp0_cause_i(cause),
    .cp0_epc_i(epc), .wb_cp0_we_i(wb_we),
    .wb_cp0_waddr_i(wb_waddr), .wb_cp0_data_i(wb_data),
    .excepttype_o(exc_o[0]), .cp0_pc_o(pc_o[0]),
    .cp0_in_delayslot_o(ds_o[0]), .cp0_int_o(int_o[0]),
    .flush_o(flush_o[0]), .new_pc_o(npc_o[0]),
    .busy_o(busy_o[0])
  );

  except_ctrl #(
    .FLUSH_CYCLES(1), .SYNC_STAGES(3)
  ) u_dut1 (
    .clk(clk), .rst(rst), .int_i(int_i),
    .mem_valid_i(mem_valid), .mem_exc_i(mem_exc),
    .mem_pc_i(mem_pc), .mem_in_delayslot_i(mem_ds),
    .cp0_status_i(status), .cp0_cause_i(cause),
    .cp0_epc_i(epc), .wb_cp0_we_i(wb_we),
    .wb_cp0_waddr_i(wb_waddr), .wb_cp0_data_i(wb_data),
    .excepttype_o(exc_o[1]), .cp0_pc_o(pc_o[1]),
    .cp0_in_delayslot_o(ds_o[1]), .cp0_int_o(int_o[1]),
    .flush_o(flush_o[1]), .new_pc_o(npc_o[1]),
    .busy_o(busy_o[1])
  );

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // highest-priority source from the applied inputs
  function automatic logic [31:0] ref_code();
    logic [31:0] st, ca;
    logic [31:0] tbl[5];
    tbl = '{32'h8, 32'ha, 32'hd, 32'hc, 32'he};
    st = (wb_we && wb_waddr == 5'd12) ? wb_data : status;
    ca = cause;
    if (wb_we && wb_waddr == 5'd13) begin
      ca[9:8]   = wb_data[9:8];
      ca[23:22] = wb_data[23:22];
    end
    if (!mem_valid) return 32'h0;
    if ((ca[15:8] & st[15:8]) != 8'h0 && st[0] && !st[1])
      return 32'h1;
    for (int k = 0; k < 5; k++)
      if (mem_exc[k]) return tbl[k];
    return 32'h0;
  endfunction

  function automatic logic [31:0] ref_epc();
    return (wb_we && wb_waddr == 5'd14) ? wb_data : epc;
  endfunction

  function automatic logic [5:0] ref_int(int s);
    if (hist.size() >= s) return hist[hist.size() - s];
    return 6'h0;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 2; i++) begin
      m_left[i] = 0;
      e_exc[i] = 0; e_pc[i] = 0; e_npc[i] = 0;
      e_ds[i] = 0; e_flush[i] = 0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("excepttype%0d", i), exc_o[i], e_exc[i]);
      chk($sformatf("cp0_pc%0d", i), pc_o[i], e_pc[i]);
      chk($sformatf("delayslot%0d", i),
          32'(ds_o[i]), 32'(e_ds[i]));
      chk($sformatf("flush%0d", i),
          32'(flush_o[i]), 32'(e_flush[i]));
      chk($sformatf("new_pc%0d", i), npc_o[i], e_npc[i]);
      chk($sformatf("busy%0d", i),
          32'(busy_o[i]), 32'(m_left[i] > 0));
      chk($sformatf("cp0_int%0d", i),
          32'(int_o[i]), 32'(ref_int(ss[i])));
    end
  endtask

  // predict one clock edge, take it, compare
  task automatic step();
    logic [31:0] code, tgt;
    code = ref_code();
    tgt = (code == 32'he) ? ref_epc() : 32'h20;
    hist.push_back(int_i);
    if (hist.size() > 3) void'(hist.pop_front());
    for (int i = 0; i < 2; i++) begin
      e_exc[i] = 0;
      if (m_left[i] > 0) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          e_flush[i] = 0; e_npc[i] = 0;
          e_pc[i] = 0; e_ds[i] = 0;
        end
      end else if (code != 0) begin
        e_exc[i] = code; e_pc[i] = mem_pc;
        e_ds[i] = mem_ds; e_flush[i] = 1;
        e_npc[i] = tgt; m_left[i] = fc[i];
      end else begin
        e_flush[i] = 0; e_npc[i] = 0;
        e_pc[i] = 0; e_ds[i] = 0;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    mem_valid = 0; mem_exc = 0; mem_pc = 0; mem_ds = 0;
    status = 0; cause = 0; epc = 0;
    wb_we = 0; wb_waddr = 0; wb_data = 0;
  endtask

  // mid-cycle reset pulse; outputs must drop at once
  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      chk("rst_flush", 32'(flush_o[i]), 32'h0);
      chk("rst_exc", exc_o[i], 32'h0);
      chk("rst_busy", 32'(busy_o[i]), 32'h0);
      chk("rst_npc", npc_o[i], 32'h0);
      chk("rst_int", 32'(int_o[i]), 32'h0);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    logic seen;
    rst = 1'b0;
    int_i = 0;
    idle_inputs();
    model_reset();
    #2;
    check_all();
    #10;
    rst = 1'b1;

    step();
    // syscall
    mem_valid = 1; mem_exc = 5'b00001; mem_pc = 32'h100;
    step();
    chk("sys_code", exc_o[0], 32'h8);
    chk("sys_pc", pc_o[0], 32'h100);
    chk("sys_npc", npc_o[0], 32'h20);
    chk("sys_flush1_fc1", 32'(flush_o[1]), 32'h1);
    idle_inputs();
    step();
    chk("sys_code_clr", exc_o[0], 32'h0);
    chk("sys_flush2", 32'(flush_o[0]), 32'h1);
    chk("sys_flush_fc1_end", 32'(flush_o[1]), 32'h0);
    step();
    chk("sys_flush_end", 32'(flush_o[0]), 32'h0);

    // eret with EPC forwarded from WB
    mem_valid = 1; mem_exc = 5'b10000; mem_pc = 32'h200;
    epc = 0; wb_we = 1; wb_waddr = 5'd14;
    wb_data = 32'h400;
    step();
    chk("eret_code", exc_o[0], 32'he);
    chk("eret_npc", npc_o[0], 32'h400);
    idle_inputs();
    repeat (3) step();

    // interrupt through the synchroniser, Cause fed back
    int_i = 6'h01; mem_valid = 1; status = 32'h00000401;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      cause = {16'h0, int_o[0], 10'h0};
      step();
      if (exc_o[0] == 32'h1) seen = 1;
    end
    chk("int_enabled_seen", 32'(seen), 32'h1);
    idle_inputs();
    repeat (3) step();
    status = 32'h00000403; mem_valid = 1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      cause = {16'h0, int_o[0], 10'h0};
      step();
      if (exc_o[0] != 32'h0) seen = 1;
    end
    chk("int_exl_masked", 32'(seen), 32'h0);
    int_i = 0;
    idle_inputs();
    repeat (4) step();

    // priority + delay slot, then ignored during FLUSH
    mem_valid = 1; mem_exc = 5'b01001; mem_ds = 1;
    mem_pc = 32'h300;
    cause = 32'h00000100; status = 32'h00000101;
    step();
    chk("prio_code", exc_o[0], 32'h1);
    chk("prio_ds", 32'(ds_o[0]), 32'h1);
    status = 0; cause = 0; mem_exc = 5'b00010;
    step();
    chk("flush_ignore", exc_o[0], 32'h0);
    idle_inputs();
    repeat (2) step();

    // bubble suppresses every source
    mem_exc = 5'b11111; mem_valid = 0;
    cause = 32'h00000100; status = 32'h00000101;
    repeat (2) step();
    chk("bubble_exc", exc_o[0], 32'h0);
    chk("bubble_flush", 32'(flush_o[0]), 32'h0);

    // reset one cycle into FLUSH
    idle_inputs();
    mem_valid = 1; mem_exc = 5'b00100; mem_pc = 32'h500;
    step();
    idle_inputs();
    do_reset();
    step();
    chk("post_rst_flush", 32'(flush_o[0]), 32'h0);
    chk("post_rst_exc", exc_o[0], 32'h0);
    step();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      mem_valid = ($urandom_range(0, 3) != 0);
      mem_exc = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h0;
      mem_pc = $urandom;
      mem_ds = 1'($urandom);
      status = $urandom;
      cause = $urandom_range(0, 1) ? $urandom : 32'h0;
      epc = $urandom;
      wb_we = 1'($urandom);
      case ($urandom_range(0, 4))
        0: wb_waddr = 5'd12;
        1: wb_waddr = 5'd13;
        2: wb_waddr = 5'd14;
        default: wb_waddr = 5'($urandom);
      endcase
      wb_data = $urandom;
      if ($urandom_range(0, 4) == 0) int_i = 6'($urandom);
      if ($urandom_range(0, 99) == 0) do_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
